// File: rtl/obi_mgr_be_if.sv
// Command, OBI A/R channel and response signals of the byte-enabled OBI manager.
// Latency: none, wires only.
// Backpressure: cmd/rsp use valid/ready; OBI A uses req/gnt and R uses rvalid/rready.
interface obi_mgr_be_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // command port
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [ADDR_WIDTH-1:0]   cmd_addr_i;
    logic                    cmd_we_i;
    logic [DATA_WIDTH/8-1:0] cmd_be_i;
    logic [DATA_WIDTH-1:0]   cmd_wdata_i;
    // OBI A channel
    logic                    obi_req_o;
    logic                    obi_gnt_i;
    logic [ADDR_WIDTH-1:0]   obi_addr_o;
    logic                    obi_we_o;
    logic [DATA_WIDTH/8-1:0] obi_be_o;
    logic [DATA_WIDTH-1:0]   obi_wdata_o;
    // OBI R channel
    logic                    obi_rvalid_i;
    logic                    obi_rready_o;
    logic [DATA_WIDTH-1:0]   obi_rdata_i;
    logic                    obi_err_i;
    // response port
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    logic                    rsp_we_o;

    // manager side
    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i, rsp_ready_i,
        output cmd_ready_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_rready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o
    );

    // environment side: command source, OBI slave and response sink
    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i, rsp_ready_i,
        input  cmd_ready_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_rready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o
    );
endinterface

// File: rtl/obi_mgr_be.sv
// Byte-enabled OBI manager: one command becomes one OBI transaction, responses are buffered in order.
// Latency: obi_req_o one cycle after command accept; response visible one cycle after the R handshake.
// Backpressure: cmd_ready_o drops while a request is pending or MAX_OUTSTANDING are in flight; obi_rready_o drops when the response FIFO is full.
module obi_mgr_be #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RSP_DEPTH       = 2
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    obi_mgr_be_if.master   bus,
    output logic           proto_err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW       = 1 << CW;
    localparam int PW       = $clog2(RSP_DEPTH);
    localparam int OW       = PW + 1;

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] FULL_OCC = OW'(RSP_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  we;
    } rsp_t;

    // A-channel state and held request fields
    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [BE_WIDTH-1:0]    be_q, be_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    // outstanding tracking: count plus per-transaction we bits, oldest at bit 0
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          trk_q, trk_d;
    logic [CW-1:0]          trk_idx;

    // response FIFO
    rsp_t                   rsp_mem_q [RSP_DEPTH];
    rsp_t                   rsp_mem_d [RSP_DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [OW-1:0]          occ_q, occ_d;
    rsp_t                   rsp_head;

    logic                   proto_err_q, proto_err_d;

    // handshake qualifiers
    logic                   cmd_ready;
    logic                   obi_req;
    logic                   obi_rready;
    logic                   rsp_full;
    logic                   rsp_valid;
    logic                   a_hs;
    logic                   r_hs;
    logic                   rsp_pop;

    // A-channel FSM: capture a command in IDLE, present it in REQ until granted
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cmd_ready = 1'b0;
        obi_req   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = (cnt_q < MAX_CNT);
                if (bus.cmd_valid_i && cmd_ready) begin
                    addr_d  = bus.cmd_addr_i;
                    we_d    = bus.cmd_we_i;
                    be_d    = bus.cmd_be_i;
                    wdata_d = bus.cmd_wdata_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                obi_req = 1'b1;
                if (bus.obi_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // R-channel acceptance depends only on registered count and FIFO occupancy
    always_comb begin
        rsp_full   = (occ_q == FULL_OCC);
        rsp_valid  = (occ_q != '0);
        obi_rready = (cnt_q != '0) && !rsp_full;
        a_hs       = obi_req && bus.obi_gnt_i;
        r_hs       = bus.obi_rvalid_i && obi_rready;
        rsp_pop    = rsp_valid && bus.rsp_ready_i;
    end

    // outstanding count and we tracking; a response retires the oldest entry first
    always_comb begin
        cnt_d   = cnt_q;
        trk_d   = trk_q;
        trk_idx = cnt_q;
        case ({a_hs, r_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (r_hs) begin
            trk_d   = trk_q >> 1;
            trk_idx = cnt_q - 1'b1;
        end
        if (a_hs) begin
            trk_d[trk_idx] = we_q;
        end
    end

    // response FIFO bookkeeping; pointers wrap naturally since the depth is a power of two
    always_comb begin
        rsp_mem_d = rsp_mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        if (r_hs) begin
            rsp_mem_d[wptr_q] = '{rdata: bus.obi_rdata_i, err: bus.obi_err_i, we: trk_q[0]};
            wptr_d            = wptr_q + 1'b1;
        end
        if (rsp_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({r_hs, rsp_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        rsp_head = rsp_mem_q[rptr_q];
    end

    // a response with nothing outstanding is a slave protocol violation; remember it until reset
    always_comb begin
        proto_err_d = proto_err_q;
        if (bus.obi_rvalid_i && (cnt_q == '0)) begin
            proto_err_d = 1'b1;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            trk_q       <= '0;
            rsp_mem_q   <= '{default: '0};
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            trk_q       <= trk_d;
            rsp_mem_q   <= rsp_mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.obi_req_o    = obi_req;
    assign bus.obi_addr_o   = addr_q;
    assign bus.obi_we_o     = we_q;
    assign bus.obi_be_o     = be_q;
    assign bus.obi_wdata_o  = wdata_q;
    assign bus.obi_rready_o = obi_rready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_rdata_o  = rsp_head.rdata;
    assign bus.rsp_err_o    = rsp_head.err;
    assign bus.rsp_we_o     = rsp_head.we;
    assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_obi_mgr_be.sv
// Directed bench for obi_mgr_be with a response scoreboard.
// Latency: checks sample at the falling edge, half a cycle away from the active edge.
// Backpressure: the bench plays command source, OBI slave and response sink.
module tb_obi_mgr_be;

    logic clk;
    logic reset_n;
    logic proto_err;

    int n_chk = 0;
    int n_err = 0;
    int n_rsp = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } rsp_t;

    cmd_t cmd_q[$];   // accepted, not yet granted
    logic out_q[$];   // granted, awaiting response (we bit)
    rsp_t sb_q[$];    // expected responses in order

    obi_mgr_be_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_mgr_be #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_OUTSTANDING(2),
        .RSP_DEPTH(2)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .bus        (bus.master),
        .proto_err_o(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Account for the handshakes about to happen at the next rising edge, then advance one cycle.
    task automatic nxt();
        cmd_t c;
        rsp_t e;
        if (!reset_n) begin
            cmd_q.delete();
            out_q.delete();
            sb_q.delete();
        end else begin
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                chk32("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk32("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                    chk1("rsp_err", bus.rsp_err_o, e.err);
                    chk1("rsp_we", bus.rsp_we_o, e.we);
                end
                n_rsp++;
            end
            if (bus.obi_rvalid_i && bus.obi_rready_o) begin
                chk32("r_hs_outstanding", 32'(out_q.size() != 0), 32'd1);
                if (out_q.size() != 0) begin
                    e.rdata = bus.obi_rdata_i;
                    e.err   = bus.obi_err_i;
                    e.we    = out_q.pop_front();
                    sb_q.push_back(e);
                end
            end
            if (bus.obi_req_o) begin
                chk32("req_has_cmd", 32'(cmd_q.size() != 0), 32'd1);
                if (cmd_q.size() != 0) begin
                    c = cmd_q[0];
                    chk32("obi_addr", bus.obi_addr_o, c.addr);
                    chk1("obi_we", bus.obi_we_o, c.we);
                    chk32("obi_be", 32'(bus.obi_be_o), 32'(c.be));
                    chk32("obi_wdata", bus.obi_wdata_o, c.wdata);
                    if (bus.obi_gnt_i) begin
                        out_q.push_back(c.we);
                        void'(cmd_q.pop_front());
                    end
                end
            end
            if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                c.addr  = bus.cmd_addr_i;
                c.we    = bus.cmd_we_i;
                c.be    = bus.cmd_be_i;
                c.wdata = bus.cmd_wdata_i;
                cmd_q.push_back(c);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = a;
        bus.cmd_we_i    = w;
        bus.cmd_be_i    = b;
        bus.cmd_wdata_i = d;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = bus.cmd_ready_o;
            nxt();
        end
        bus.cmd_valid_i = 1'b0;
        chk1("cmd_accept", acc, 1'b1);
    endtask

    task automatic grant();
        logic hs;
        hs = 1'b0;
        bus.obi_gnt_i = 1'b1;
        for (int k = 0; k < 40 && !hs; k++) begin
            hs = bus.obi_req_o;
            nxt();
        end
        bus.obi_gnt_i = 1'b0;
        chk1("gnt_hs", hs, 1'b1);
    endtask

    task automatic respond(input logic [31:0] d, input logic er);
        logic hs;
        hs = 1'b0;
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = d;
        bus.obi_err_i    = er;
        for (int k = 0; k < 40 && !hs; k++) begin
            hs = bus.obi_rready_o;
            nxt();
        end
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;
        chk1("r_hs", hs, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (sb_q.size() != 0 || bus.rsp_valid_o); k++) begin
            nxt();
        end
        chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        reset_n          = 1'b0;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_addr_i   = 32'h0;
        bus.cmd_we_i     = 1'b0;
        bus.cmd_be_i     = 4'h0;
        bus.cmd_wdata_i  = 32'h0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = 32'h0;
        bus.obi_err_i    = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        @(negedge clk);
        nxt();
        nxt();

        // reset state
        chk1("rst_req", bus.obi_req_o, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk1("rst_rready", bus.obi_rready_o, 1'b0);
        chk1("rst_proto", proto_err, 1'b0);
        reset_n = 1'b1;
        chk1("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        nxt();

        // single read
        issue(32'h10, 1'b0, 4'hF, 32'h0);
        chk1("rd_req", bus.obi_req_o, 1'b1);
        chk1("rd_cmd_ready", bus.cmd_ready_o, 1'b0);
        chk32("rd_addr", bus.obi_addr_o, 32'h10);
        nxt();
        chk32("rd_addr_held", bus.obi_addr_o, 32'h10);
        grant();
        chk1("rd_req_drop", bus.obi_req_o, 1'b0);
        chk1("rd_rready", bus.obi_rready_o, 1'b1);
        respond(32'hDEADBEEF, 1'b0);
        chk1("rd_rsp_valid", bus.rsp_valid_o, 1'b1);
        chk32("rd_rsp_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
        nxt();
        chk1("rd_rsp_gone", bus.rsp_valid_o, 1'b0);
        chk32("rd_rsp_count", 32'(n_rsp), 32'd1);

        // byte write then readback; write response coincides with the read grant
        issue(32'h4, 1'b1, 4'h2, 32'h0000AB00);
        chk32("wr_be", 32'(bus.obi_be_o), 32'h2);
        chk1("wr_we", bus.obi_we_o, 1'b1);
        grant();
        issue(32'h4, 1'b0, 4'hF, 32'h0);
        bus.obi_gnt_i    = 1'b1;
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = 32'h0;
        chk1("both_req", bus.obi_req_o, 1'b1);
        chk1("both_rready", bus.obi_rready_o, 1'b1);
        nxt();
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        chk1("both_cnt_rready", bus.obi_rready_o, 1'b1);
        chk1("both_cnt_cmd_ready", bus.cmd_ready_o, 1'b1);
        chk1("wr_rsp_we", bus.rsp_we_o, 1'b1);
        respond(32'h0000AB00, 1'b0);
        chk1("rb_rsp_we", bus.rsp_we_o, 1'b0);
        chk32("rb_byte1", 32'(bus.rsp_rdata_o[15:8]), 32'hAB);
        drain();

        // grant stall with a competing command held valid
        issue(32'h20, 1'b1, 4'hC, 32'h12345678);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 32'h99;
        for (int i = 0; i < 5; i++) begin
            chk1("stall_req", bus.obi_req_o, 1'b1);
            chk1("stall_cmd_ready", bus.cmd_ready_o, 1'b0);
            chk32("stall_wdata", bus.obi_wdata_o, 32'h12345678);
            nxt();
        end
        bus.cmd_valid_i = 1'b0;
        grant();
        respond(32'h0, 1'b1);
        chk1("err_pass", bus.rsp_err_o, 1'b1);
        drain();

        // backpressure: response FIFO fills, then two more reads stay outstanding
        base = n_rsp;
        bus.rsp_ready_i = 1'b0;
        issue(32'h100, 1'b0, 4'hF, 32'h0);
        grant();
        issue(32'h104, 1'b0, 4'hF, 32'h0);
        grant();
        chk1("bp_cmd_ready_max", bus.cmd_ready_o, 1'b0);
        respond(32'hA0, 1'b0);
        respond(32'hA1, 1'b0);
        chk1("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
        issue(32'h108, 1'b0, 4'hF, 32'h0);
        grant();
        issue(32'h10C, 1'b0, 4'hF, 32'h0);
        grant();
        chk1("bp_cmd_ready", bus.cmd_ready_o, 1'b0);
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            chk1("bp_rready", bus.obi_rready_o, 1'b0);
            chk1("bp_proto", proto_err, 1'b0);
            nxt();
        end
        bus.rsp_ready_i = 1'b1;
        respond(32'hA2, 1'b0);
        respond(32'hA3, 1'b0);
        drain();
        chk32("bp_delivered", 32'(n_rsp - base), 32'd4);

        // spurious response with nothing outstanding
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = 32'h55;
        chk1("sp_rready", bus.obi_rready_o, 1'b0);
        nxt();
        bus.obi_rvalid_i = 1'b0;
        chk1("sp_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk1("sp_proto", proto_err, 1'b1);
        nxt();
        nxt();
        chk1("sp_proto_sticky", proto_err, 1'b1);

        // reset while a request is pending and ungranted
        issue(32'h40, 1'b0, 4'hF, 32'h0);
        chk1("mr_req", bus.obi_req_o, 1'b1);
        nxt();
        reset_n = 1'b0;
        nxt();
        chk1("mr_req_drop", bus.obi_req_o, 1'b0);
        chk1("mr_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk1("mr_rready", bus.obi_rready_o, 1'b0);
        chk1("mr_proto_clr", proto_err, 1'b0);
        reset_n = 1'b1;
        chk1("mr_cmd_ready", bus.cmd_ready_o, 1'b1);
        nxt();
        chk1("mr_idle", bus.obi_req_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/obi_mgr_be.md
Name: obi_mgr_be

Overview:
- Byte-enabled OBI manager that sits directly upstream of the byte-enabled OBI slave memory and drives its A channel.
- Accepts simple commands (addr/we/be/wdata) over a valid/ready port and converts each into one OBI transaction.
- Tracks outstanding transactions and buffers R-channel responses in a small FIFO, returned on a valid/ready response port.
- Flags responses that arrive with nothing outstanding.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..7).
- RSP_DEPTH, 2, response FIFO depth (power of two, at least 2).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_ni  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted this cycle when valid and ready are both high.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_be_i  in  DATA_WIDTH/8  byte enables.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  ADDR_WIDTH  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  DATA_WIDTH/8  OBI byte enables.
- obi_wdata_o  out  DATA_WIDTH  OBI write data.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rready_o  out  1  OBI response ready.
- obi_rdata_i  in  DATA_WIDTH  OBI read data.
- obi_err_i  in  1  OBI error.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_WIDTH  response data (FIFO head).
- rsp_err_o  out  1  response error flag.
- rsp_we_o  out  1  1 if the response belongs to a write.
- proto_err_o  out  1  sticky: rvalid seen with zero outstanding.

Behaviour:
- Reset: synchronous, active-low, sampled at the rising edge of clk_i. State <= IDLE, outstanding count <= 0, both FIFOs emptied, A-channel registers <= 0, proto_err_o <= 0.
- Outputs in the cycle after reset: obi_req_o=0, rsp_valid_o=0, obi_rready_o=0, cmd_ready_o=1.
- A-channel FSM, states IDLE and REQ:
  - IDLE: cmd_ready_o = (count < MAX_OUTSTANDING). On cmd_valid_i && cmd_ready_o, register addr/we/be/wdata and go to REQ.
  - REQ: obi_req_o=1 and cmd_ready_o=0. obi_addr/we/be/wdata_o are driven from registers and held stable until grant. On obi_gnt_i go to IDLE.
  - obi_req_o is registered: first assertion is one cycle after command acceptance. Minimum command spacing is 2 cycles.
- Address handshake (obi_req_o && obi_gnt_i):
  - count+1.
  - Push the transaction's we bit into a MAX_OUTSTANDING-deep tracking FIFO.
- R-channel:
  - obi_rready_o = (count != 0) && response FIFO not full. It is derived from registered state only, with no combinational path from rsp_ready_i.
  - Handshake (obi_rvalid_i && obi_rready_o): push {obi_rdata_i, obi_err_i, popped tracking we} into the response FIFO; count-1.
  - The slave may answer in the cycle immediately after grant.
  - Response latency: response FIFO entry visible on rsp_* one cycle after the R handshake.
- Simultaneous address handshake and R handshake: count unchanged; tracking FIFO push and pop both occur.
- Response FIFO: pop on rsp_valid_o && rsp_ready_i. Simultaneous push and pop allowed when not full. Pointers wrap modulo RSP_DEPTH. Occupancy counter is width clog2(RSP_DEPTH)+1.
- obi_rvalid_i while count==0: no handshake, rready stays 0, nothing pushed, proto_err_o set to 1 until reset.
- Count never exceeds MAX_OUTSTANDING and never underflows; the control above guarantees both.
- obi_err_i is passed through per response and does not alter FSM flow.
- Reset mid-transaction: obi_req_o drops in the next cycle even if not granted. In-flight responses are lost and count returns to 0.

Test Plan:
- Single read: cmd addr=0x10, we=0, be=0xF; slave grants, then returns rdata=0xDEADBEEF -> obi_req_o high 1 cycle after accept, addr 0x10 stable until gnt; rsp_valid_o with rdata 0xDEADBEEF, err=0, we=0.
- Byte write then readback: write addr=0x4, be=0x2, wdata=0x0000AB00, then read addr=0x4 -> obi_be_o=0x2 during the write request, rsp_we_o=1 then 0; read data byte1=0xAB.
- Grant stall: hold obi_gnt_i=0 for 5 cycles -> obi_req_o and addr/we/be/wdata unchanged for all 5 cycles, cmd_ready_o=0 throughout.
- Backpressure: MAX_OUTSTANDING=2, RSP_DEPTH=2, rsp_ready_i=0, issue 4 reads -> after 2 responses buffered, obi_rready_o=0 and cmd_ready_o=0; release rsp_ready_i -> all 4 responses delivered in order, no loss.
- Spurious response: obi_rvalid_i=1 with no command issued -> obi_rready_o=0, rsp_valid_o=0, proto_err_o=1 until reset.
- Reset mid-operation: reset_ni=0 while obi_req_o=1 and ungranted -> next cycle obi_req_o=0, rsp_valid_o=0, cmd_ready_o=1 after release.
